// File: rtl/sobel_gradient_unit_pkg.sv
// Shared types, widths and defaults for the Sobel gradient pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sobel_gradient_unit_pkg;

  localparam int NBIT_DEF        = 8;
  localparam int KERNEL_SIZE_DEF = 3;

  // Signed gradient width: room for +/-4*(2^nbit-1) plus sign.
  function automatic int calc_gw(input int nbit);
    return $clog2((nbit + 1) * 3) + nbit;
  endfunction

  // Unsigned L1 magnitude width: |gx|+|gy| needs one more bit than a gradient.
  function automatic int calc_mw(input int nbit);
    return calc_gw(nbit) + 1;
  endfunction

  typedef enum logic [1:0] {
    ANG_0   = 2'd0,
    ANG_45  = 2'd1,
    ANG_90  = 2'd2,
    ANG_135 = 2'd3
  } angle_e;

endpackage

// File: rtl/sobel_mag_dir.sv
// Stage 2: L1 gradient magnitude and quantized direction from registered gx/gy.
// Latency: 1 cycle from valid to o_valid; outputs hold when valid is low.
// Backpressure: none, accepts one gradient pair per cycle.
module sobel_mag_dir
  import sobel_gradient_unit_pkg::*;
#(
  parameter int GW = 13,
  parameter int MW = 14
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic signed [GW-1:0] gx,
  input  logic signed [GW-1:0] gy,
  input  logic                 valid,
  output logic [MW-1:0]        module_g,
  output logic [1:0]           angle_range,
  output logic                 o_valid
);

  // Products of a GW-bit magnitude with a 9-bit constant stay exact in PW bits.
  localparam int PW = GW + 9;

  logic signed [MW-1:0] gx_ext, gy_ext;
  logic [MW-1:0]        ax, ay, mag_nxt;
  logic [PW-1:0]        ay_128, ax_53, ax_309;
  angle_e               ang_nxt;

  assign gx_ext  = MW'(gx);
  assign gy_ext  = MW'(gy);
  assign ax      = gx_ext[MW-1] ? $unsigned(-gx_ext) : $unsigned(gx_ext);
  assign ay      = gy_ext[MW-1] ? $unsigned(-gy_ext) : $unsigned(gy_ext);
  assign mag_nxt = ax + ay;

  // tan(22.5 deg) ~ 53/128 and tan(67.5 deg) ~ 309/128, compared without division.
  assign ay_128 = PW'(ay) << 7;
  assign ax_53  = PW'(ax) * PW'(53);
  assign ax_309 = PW'(ax) * PW'(309);

  // Direction bins, first match wins; a zero gradient falls into the 0-degree bin.
  always_comb begin
    ang_nxt = ANG_135;
    if (ay_128 <= ax_53)           ang_nxt = ANG_0;
    else if (ay_128 >= ax_309)     ang_nxt = ANG_90;
    else if (gx[GW-1] == gy[GW-1]) ang_nxt = ANG_45;
  end

  // Result register loads only on a valid gradient pair; valid is a plain delay.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      module_g    <= '0;
      angle_range <= 2'd0;
      o_valid     <= 1'b0;
    end else begin
      o_valid <= valid;
      if (valid) begin
        module_g    <= mag_nxt;
        angle_range <= ang_nxt;
      end
    end
  end

endmodule

// File: rtl/sobel_gradient_unit.sv
// 3x3 Sobel gradients (stage 1) followed by magnitude/direction (stage 2).
// Latency: gx/gy 1 cycle, module_g/angle_range 2 cycles after i_data_valid.
// Backpressure: none, fully pipelined at one window per cycle.
module sobel_gradient_unit
  import sobel_gradient_unit_pkg::*;
#(
  parameter  int NBIT        = NBIT_DEF,
  parameter  int KERNEL_SIZE = KERNEL_SIZE_DEF,
  localparam int GW          = calc_gw(NBIT),
  localparam int MW          = calc_mw(NBIT)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NBIT-1:0]      i_data [3][3],
  input  logic                 i_data_valid,
  output logic signed [GW-1:0] gx,
  output logic signed [GW-1:0] gy,
  output logic                 o_grad_valid,
  output logic [MW-1:0]        module_g,
  output logic [1:0]           angle_range,
  output logic                 o_valid
);

  if (KERNEL_SIZE != 3) begin : g_bad_kernel
    $error("sobel_gradient_unit: KERNEL_SIZE must be 3");
  end

  logic signed [GW-1:0] px [3][3];
  logic signed [GW-1:0] gx_nxt, gy_nxt;

  // Zero-extend pixels into the signed gradient domain so all sums are exact.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        px[r][c] = $signed({{(GW-NBIT){1'b0}}, i_data[r][c]});
      end
    end
  end

  assign gx_nxt = (px[0][2] + (px[1][2] <<< 1) + px[2][2])
                - (px[0][0] + (px[1][0] <<< 1) + px[2][0]);
  assign gy_nxt = (px[2][0] + (px[2][1] <<< 1) + px[2][2])
                - (px[0][0] + (px[0][1] <<< 1) + px[0][2]);

  // Gradient register loads only on a valid window; valid is a plain delay.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gx           <= '0;
      gy           <= '0;
      o_grad_valid <= 1'b0;
    end else begin
      o_grad_valid <= i_data_valid;
      if (i_data_valid) begin
        gx <= gx_nxt;
        gy <= gy_nxt;
      end
    end
  end

  sobel_mag_dir #(
    .GW (GW),
    .MW (MW)
  ) u_mag_dir (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .gx          (gx),
    .gy          (gy),
    .valid       (o_grad_valid),
    .module_g    (module_g),
    .angle_range (angle_range),
    .o_valid     (o_valid)
  );

endmodule

// File: tb/tb_sobel_gradient_unit.sv
// Self-checking bench for sobel_gradient_unit: directed table, random stream, reset.
// Latency: checks gx/gy one cycle and module_g/angle_range two cycles after input.
// Backpressure: none expected; valid driven every cycle in the streaming phase.
module tb_sobel_gradient_unit;

  localparam int GW = 13;
  localparam int MW = 14;

  typedef logic [8:0][7:0] pix9_t;  // byte k = row*3 + col

  typedef struct {
    string name;
    pix9_t w;
    int    egx;
    int    egy;
    int    emag;
    int    eang;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [7:0]           i_data [3][3];
  logic                 dv;
  logic signed [GW-1:0] gx, gy;
  logic                 gvld;
  logic [MW-1:0]        mag;
  logic [1:0]           ang;
  logic                 ovld;

  int n_vec = 0;
  int n_bad = 0;

  // Reference pipeline state: what each output register should hold.
  int m_gx = 0, m_gy = 0, m_mag = 0, m_ang = 0;
  int m_gvld = 0, m_ovld = 0;

  always #5 clk = ~clk;

  sobel_gradient_unit dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data       (i_data),
    .i_data_valid (dv),
    .gx           (gx),
    .gy           (gy),
    .o_grad_valid (gvld),
    .module_g     (mag),
    .angle_range  (ang),
    .o_valid      (ovld)
  );

  function automatic pix9_t mk9(input int a00, a01, a02, a10, a11, a12, a20, a21, a22);
    pix9_t w;
    w[0] = 8'(a00); w[1] = 8'(a01); w[2] = 8'(a02);
    w[3] = 8'(a10); w[4] = 8'(a11); w[5] = 8'(a12);
    w[6] = 8'(a20); w[7] = 8'(a21); w[8] = 8'(a22);
    return w;
  endfunction

  function automatic int px(input pix9_t w, input int r, input int c);
    return int'(w[r*3+c]);
  endfunction

  function automatic int ref_gx(input pix9_t w);
    return (px(w,0,2) + 2*px(w,1,2) + px(w,2,2)) - (px(w,0,0) + 2*px(w,1,0) + px(w,2,0));
  endfunction

  function automatic int ref_gy(input pix9_t w);
    return (px(w,2,0) + 2*px(w,2,1) + px(w,2,2)) - (px(w,0,0) + 2*px(w,0,1) + px(w,0,2));
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int ref_ang(input int x, input int y);
    int ax, ay;
    ax = iabs(x);
    ay = iabs(y);
    if (128*ay <= 53*ax)            return 0;
    if (128*ay >= 309*ax)           return 2;
    if ((x > 0 && y > 0) || (x < 0 && y < 0)) return 1;
    return 3;
  endfunction

  function automatic pix9_t rnd9();
    pix9_t w;
    for (int k = 0; k < 9; k++) w[k] = 8'($urandom_range(0, 255));
    return w;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("gx",           int'(gx),   m_gx);
    chk("gy",           int'(gy),   m_gy);
    chk("o_grad_valid", int'(gvld), m_gvld);
    chk("module_g",     int'(mag),  m_mag);
    chk("angle_range",  int'(ang),  m_ang);
    chk("o_valid",      int'(ovld), m_ovld);
  endtask

  // Drive one window, clock once, advance the reference and compare everything.
  task automatic step(input pix9_t w, input bit v);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        i_data[r][c] = w[r*3+c];
    dv = v;
    @(posedge clk);
    if (m_gvld != 0) begin
      m_mag = iabs(m_gx) + iabs(m_gy);
      m_ang = ref_ang(m_gx, m_gy);
    end
    m_ovld = m_gvld;
    if (v) begin
      m_gx = ref_gx(w);
      m_gy = ref_gy(w);
    end
    m_gvld = int'(v);
    if (!rst_n) model_clear();
    #1;
    check_all();
  endtask

  task automatic model_clear();
    m_gx = 0; m_gy = 0; m_mag = 0; m_ang = 0; m_gvld = 0; m_ovld = 0;
  endtask

  vec_t tbl [6];

  initial begin
    tbl[0] = '{"flat_100",  mk9(100,100,100, 100,100,100, 100,100,100),    0,    0,    0, 0};
    tbl[1] = '{"vert_edge", mk9(0,77,255, 0,77,255, 0,77,255),          1020,    0, 1020, 0};
    tbl[2] = '{"horz_edge", mk9(0,0,0, 50,50,50, 255,255,255),             0, 1020, 1020, 2};
    tbl[3] = '{"p22_only",  mk9(0,0,0, 0,0,0, 0,0,255),                  255,  255,  510, 1};
    tbl[4] = '{"p20_only",  mk9(0,0,0, 0,0,0, 255,0,0),                 -255,  255,  510, 3};
    tbl[5] = '{"p00_only",  mk9(255,0,0, 0,0,0, 0,0,0),                 -255, -255,  510, 1};

    rst_n = 1'b0;
    dv    = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        i_data[r][c] = 8'd0;
    #3;
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed table: gradients after one cycle, magnitude/direction after two.
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].w, 1'b1);
      chk({tbl[i].name, "_gx"}, int'(gx), tbl[i].egx);
      chk({tbl[i].name, "_gy"}, int'(gy), tbl[i].egy);
      step('0, 1'b0);
      chk({tbl[i].name, "_mag"}, int'(mag), tbl[i].emag);
      chk({tbl[i].name, "_ang"}, int'(ang), tbl[i].eang);
      step('0, 1'b0);
    end

    // Back-to-back stream: one result per cycle, no bubbles.
    for (int i = 0; i < 300; i++) step(rnd9(), 1'b1);
    chk("stream_ovld_continuous", int'(ovld), 1);

    // Sparse random valids: registers must hold between loads.
    for (int i = 0; i < 300; i++) step(rnd9(), 1'($urandom_range(0, 1)));
    step('0, 1'b0);
    step('0, 1'b0);

    // Reset one cycle after a valid input: everything clears immediately.
    step(rnd9(), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_all();
    step(rnd9(), 1'b0);
    step(rnd9(), 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(rnd9(), 1'b0);
      chk("post_rst_no_ovld", int'(ovld), 0);
    end
    step(mk9(0,0,0, 0,0,0, 0,0,255), 1'b1);
    chk("post_rst_gvld_1cyc", int'(gvld), 1);
    chk("post_rst_ovld_not_yet", int'(ovld), 0);
    step('0, 1'b0);
    chk("post_rst_ovld_2cyc", int'(ovld), 1);
    chk("post_rst_mag", int'(mag), 510);
    step('0, 1'b0);
    chk("post_rst_ovld_drop", int'(ovld), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
